gift_dec_key_store: RTL and testbench
=====================================

// Module: gift_dec_key_store
// PURPOSE
// - Round-key store for the GIFT-128 decryptor; sits directly downstream of the decryption key-schedule register.
// - Fill phase: steps the key-schedule register once per cycle and writes each 136-bit word {key, 2'b0, rc} to a RAM.
// - Serve phase: returns round keys to the decryption datapath in reverse order (last round first), one per request.
// PARAMETERS
// - ROUNDS  40   number of round keys stored (GIFT-128)
// - DATA_W  136  stored word width {key[127:0], pad[1:0], rc[5:0]}
// - ADDR_W  6    RAM address width; ROUNDS <= 2**ADDR_W
// PORTS
// - inClk        in   1    clock, rising edge
// - inRstN       in   1    asynchronous active-low reset
// - inStart      in   1    begin fill; key-schedule register already holds the user key with rc=1
// - inSchedData  in   136  key-schedule register word {key, 2'b0, rc}
// - outSchedStep out  1    advance key-schedule register one round (drives its internal write)
// - inRdReq      in   1    request next round key (serve phase)
// - inRewind     in   1    reset read pointer to ROUNDS-1 (start of a new block)
// - outRk        out  128  round key
// - outRc        out  6    round constant paired with outRk
// - outRkValid   out  1    one-cycle pulse: outRk/outRc valid
// - outLoaded    out  1    store is full and ready to serve
// - outBusy      out  1    fill in progress
// BEHAVIOUR
// - Reset (async, inRstN=0): state IDLE; wrAddr=0, rdPtr=ROUNDS-1; all outputs 0. RAM contents undefined.
// - FSM states IDLE, FILL, READY.
// - IDLE: inStart=1 -> FILL (wrAddr=0). inRdReq and inRewind are ignored.
// - FILL: each cycle write inSchedData to RAM[wrAddr] and increment wrAddr.
//   outSchedStep=1 while wrAddr < ROUNDS-1, so the register holds round wrAddr+1 on the next cycle.
//   After the write at wrAddr=ROUNDS-1: go to READY, set outLoaded=1, set rdPtr=ROUNDS-1. Fill takes exactly ROUNDS cycles.
//   outBusy=1 throughout FILL. inStart, inRdReq and inRewind are ignored.
// - READY: inRdReq=1 -> RAM read at rdPtr (synchronous); outRk/outRc/outRkValid appear the next cycle (latency 1).
//   rdPtr decrements per request; a request at rdPtr=0 wraps rdPtr to ROUNDS-1.
//   Back-to-back requests are supported: one key per cycle.
// - outRk=RAM[135:8], outRc=RAM[5:0]. Pad bits [7:6] are stored but never output.
// - outRk/outRc hold their last value when outRkValid=0.
// - Priority in READY: inStart > inRewind > inRdReq.
//   inStart drops outLoaded, re-enters FILL and drops any read issued that cycle.
//   inRewind sets rdPtr=ROUNDS-1 and drops any read issued that cycle.
// - Reset during FILL or READY: immediate return to IDLE; outLoaded=0; no further outSchedStep.
// - Requires ROUNDS >= 2.
// STRUCTURE
// - Shared package gift_pkg: GIFT_ROUNDS=40, KEY_W=128, RC_W=6, KEYMEM_W=136, state enum {IDLE,FILL,READY}.
// - One sub-module gift_key_ram: simple dual-port, sync write and sync read, DATA_W x ROUNDS, no reset.
// - Top level holds the FSM, wrAddr and rdPtr counters, and the output valid register.
// TESTING
// - Reset, then idle 5 cycles -> all outputs 0; inRdReq pulses yield no outRkValid.
// - User key 0x0123..CDEF in the stub register, pulse inStart -> outSchedStep high 39 cycles, outBusy 40 cycles,
//   then outLoaded=1.
// - 40 back-to-back inRdReq -> 40 outRkValid pulses; outRc sequence 0x1A,0x2D,0x36,...,0x03,0x01;
//   each outRk matches the golden key-schedule model.
// - 41st inRdReq -> wraps; returns rc 0x1A and the round-40 key again.
// - After 7 reads, inRewind and inRdReq together -> no valid pulse; the next inRdReq returns rc 0x1A.
// - Pulse inRstN=0 at fill cycle 20 -> IDLE, outLoaded=0, outSchedStep=0.
//   A new inStart refills correctly and the first read returns rc 0x1A.

Source files
------------

// File: rtl/gift_pkg.sv
// Shared types and sizes for the GIFT-128 decryption round-key store.
// Holds the round count, field widths and the store FSM state type.
package gift_pkg;

    localparam int GIFT_ROUNDS = 40;
    localparam int KEY_W       = 128;
    localparam int RC_W        = 6;
    localparam int KEYMEM_W    = 136;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READY
    } state_t;

endpackage

// File: rtl/gift_dec_key_store_if.sv
// Serve-side bundle between the key store and the decryption datapath.
// The datapath (master) requests/rewinds; the store (slave) returns rk/rc.
interface gift_dec_key_store_if;
    import gift_pkg::*;

    logic             inRdReq;
    logic             inRewind;
    logic [KEY_W-1:0] outRk;
    logic [RC_W-1:0]  outRc;
    logic             outRkValid;

    modport master (
        output inRdReq,
        output inRewind,
        input  outRk,
        input  outRc,
        input  outRkValid
    );

    modport slave (
        input  inRdReq,
        input  inRewind,
        output outRk,
        output outRc,
        output outRkValid
    );

endinterface

// File: rtl/gift_key_ram.sv
// Simple dual-port round-key RAM: sync write, sync read with enable.
// Ports: inClk, i_we/i_waddr/i_wdata (write), i_re/i_raddr/o_rdata (read).
module gift_key_ram #(
    parameter int DATA_W = 136,
    parameter int DEPTH  = 40,
    parameter int ADDR_W = 6
) (
    input  logic              inClk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // No reset: contents are always rewritten by a fill before use.
    always_ff @(posedge inClk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/gift_dec_key_store.sv
// GIFT-128 decryption round-key store: fills from the key schedule, then
// serves keys last-round-first. Ports: inClk, inRstN, inStart, inSchedData,
// outSchedStep, outLoaded, outBusy, rdIf (rdReq/rewind in; rk/rc/valid out).
module gift_dec_key_store
    import gift_pkg::*;
#(
    parameter int ROUNDS = GIFT_ROUNDS,
    parameter int DATA_W = KEYMEM_W,
    parameter int ADDR_W = 6
) (
    input  logic                  inClk,
    input  logic                  inRstN,
    input  logic                  inStart,
    input  logic [DATA_W-1:0]     inSchedData,
    output logic                  outSchedStep,
    output logic                  outLoaded,
    output logic                  outBusy,
    gift_dec_key_store_if.slave   rdIf
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROUNDS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic              r_valid;
    logic              r_seen;

    logic              w_fillEnd;
    logic              w_rd;
    logic              w_rewind;
    logic [DATA_W-1:0] w_rdata;
    logic [1:0]        w_unusedPad;

    assign w_fillEnd = (r_state == FILL) && (r_wrAddr == LAST);

    // inStart outranks inRewind, which outranks inRdReq.
    assign w_rewind = (r_state == READY) && !inStart && rdIf.inRewind;
    assign w_rd     = (r_state == READY) && !inStart
                    && !rdIf.inRewind && rdIf.inRdReq;

    always_comb begin
        w_next       = r_state;
        outBusy      = 1'b0;
        outLoaded    = 1'b0;
        outSchedStep = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (inStart) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                outBusy      = 1'b1;
                outSchedStep = (r_wrAddr < LAST);
                if (w_fillEnd) begin
                    w_next = READY;
                end
            end
            READY: begin
                outLoaded = 1'b1;
                if (inStart) begin
                    w_next = FILL;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            r_state  <= IDLE;
            r_wrAddr <= '0;
            r_rdPtr  <= LAST;
            r_valid  <= 1'b0;
            r_seen   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_rd;

            if (r_state == FILL) begin
                r_wrAddr <= w_fillEnd ? '0 : r_wrAddr + 1'b1;
            end else begin
                r_wrAddr <= '0;
            end

            if (w_fillEnd || w_rewind) begin
                r_rdPtr <= LAST;
            end else if (w_rd) begin
                r_rdPtr <= (r_rdPtr == '0) ? LAST : r_rdPtr - 1'b1;
            end

            // Outputs read zero until the first key has been served.
            if (w_rd) begin
                r_seen <= 1'b1;
            end
        end
    end

    gift_key_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (ROUNDS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .inClk   (inClk),
        .i_we    (r_state == FILL),
        .i_waddr (r_wrAddr),
        .i_wdata (inSchedData),
        .i_re    (w_rd),
        .i_raddr (r_rdPtr),
        .o_rdata (w_rdata)
    );

    // Pad bits [7:6] are stored but never leave the block.
    assign w_unusedPad     = w_rdata[7:6];
    assign rdIf.outRk      = r_seen ? w_rdata[DATA_W-1:8] : '0;
    assign rdIf.outRc      = r_seen ? w_rdata[5:0] : '0;
    assign rdIf.outRkValid = r_valid;

endmodule

// File: tb/tb_gift_dec_key_store.sv
// Directed self-checking bench for gift_dec_key_store.
// A stub key-schedule register feeds the store; keys checked vs a model.
module tb_gift_dec_key_store;
    import gift_pkg::*;

    localparam logic [127:0] USER_KEY = 128'h0123456789ABCDEF0123456789ABCDEF;

    // GIFT-128 round constants for rounds 1..40.
    localparam logic [5:0] RC_TBL [40] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B,
        6'h37, 6'h2F, 6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E,
        6'h1D, 6'h3A, 6'h35, 6'h2B, 6'h16, 6'h2C, 6'h18, 6'h30,
        6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E, 6'h1C, 6'h38,
        6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
    };

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         load;
    logic [135:0] sched;
    logic         step;
    logic         loaded;
    logic         busy;
    logic [127:0] s_key;
    logic [5:0]   s_rc;
    logic [127:0] gk [40];

    int errors;
    int checks;

    gift_dec_key_store_if rdIf ();

    gift_dec_key_store dut (
        .inClk        (clk),
        .inRstN       (rst_n),
        .inStart      (start),
        .inSchedData  (sched),
        .outSchedStep (step),
        .outLoaded    (loaded),
        .outBusy      (busy),
        .rdIf         (rdIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] key_upd(input logic [127:0] k);
        logic [15:0] k1;
        logic [15:0] k0;
        k1 = k[31:16];
        k0 = k[15:0];
        return {{k1[1:0], k1[15:2]}, {k0[11:0], k0[15:12]}, k[127:32]};
    endfunction

    function automatic logic [5:0] rc_upd(input logic [5:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    // Stub key-schedule register stepped by the DUT.
    always @(posedge clk) begin
        if (load) begin
            s_key <= USER_KEY;
            s_rc  <= 6'h01;
        end else if (step) begin
            s_key <= key_upd(s_key);
            s_rc  <= rc_upd(s_rc);
        end
    end

    assign sched = {s_key, 2'b00, s_rc};

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_store();
        int ns;
        int nb;
        ns = 0;
        nb = 0;
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (loaded) break;
            ns += int'(step);
            nb += int'(busy);
        end
        chk("fill_done", loaded, 1);
        chk("fill_busy_after", busy, 0);
        chk("fill_step_cnt", ns, 39);
        chk("fill_busy_cnt", nb, 40);
    endtask

    // n back-to-back reads; expected addresses count down from p.
    task automatic read_run(input int n, input int p);
        int a;
        a = p;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("rd_valid", rdIf.outRkValid, 1);
                chk("rd_rc", rdIf.outRc, RC_TBL[a]);
                chk("rd_rk", rdIf.outRk, gk[a]);
                a = (a == 0) ? 39 : a - 1;
            end
            rdIf.inRdReq = (i < n);
        end
        @(negedge clk);
        chk("rd_valid_drop", rdIf.outRkValid, 0);
    endtask

    task automatic rewind_with_read();
        @(negedge clk);
        rdIf.inRewind = 1'b1;
        rdIf.inRdReq  = 1'b1;
        @(negedge clk);
        rdIf.inRewind = 1'b0;
        rdIf.inRdReq  = 1'b0;
        chk("rewind_no_valid", rdIf.outRkValid, 0);
        @(negedge clk);
        chk("rewind_no_valid2", rdIf.outRkValid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        load          = 1'b0;
        rdIf.inRdReq  = 1'b0;
        rdIf.inRewind = 1'b0;
        gk[0] = USER_KEY;
        for (int i = 1; i < 40; i++) begin
            gk[i] = key_upd(gk[i-1]);
        end

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_step", step, 0);
        chk("rst_valid", rdIf.outRkValid, 0);
        chk("rst_rk", rdIf.outRk, 0);
        chk("rst_rc", rdIf.outRc, 0);
        rst_n = 1'b1;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle_valid", rdIf.outRkValid, 0);
            chk("idle_step", step, 0);
            chk("idle_busy", busy, 0);
            chk("idle_loaded", loaded, 0);
            chk("idle_rk", rdIf.outRk, 0);
            rdIf.inRdReq  = (c == 1 || c == 2);
            rdIf.inRewind = (c == 3);
        end
        rdIf.inRdReq  = 1'b0;
        rdIf.inRewind = 1'b0;

        fill_store();
        chk("ready_step", step, 0);

        read_run(40, 39);
        read_run(1, 39);

        rewind_with_read();
        read_run(7, 39);
        rewind_with_read();
        read_run(1, 39);

        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_busy", busy, 1);
        chk("mid_step", step, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_loaded", loaded, 0);
        chk("arst_step", step, 0);
        chk("arst_rk", rdIf.outRk, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_step", step, 0);
        chk("post_rst_busy", busy, 0);

        fill_store();
        read_run(1, 39);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
